lcd_dma_reader: RTL and testbench
=================================

// Module: lcd_dma_reader
// PURPOSE
//  AXI3 burst-read master feeding lcd_controller's DMA interface; attaches to a Zynq HP slave port.
//  Per DMA_START: one INCR burst of BURST_BEATS x 64-bit beats.
//  Each beat is split into two 32-bit words (low half first) on DMA_RD_DATA/DMA_RD_DATA_VALID.
//  DMA_READY reports when the next burst may be requested.
// PARAMETERS
//  BURST_BEATS  4  64-bit beats per burst, 1..16 (AXI3 limit); power of two
// PORTS
//  CLK                 in   1   single clock for DMA side and AXI port
//  RESET               in   1   synchronous reset, active high
//  DMA_RD_ADDR         in   30  burst start, 64-bit-word address (byte addr = {addr,3'b0}, bit 29 dropped)
//  DMA_START           in   1   one-cycle request, honoured only while DMA_READY==1
//  DMA_READY           out  1   1 = idle, may accept DMA_START
//  DMA_RD_DATA         out  32  read word; 0 when DMA_RD_DATA_VALID==0
//  DMA_RD_DATA_VALID   out  1   1 for one CLK per word; no backpressure (consumer FIFO always accepts)
//  DMA_ERROR           out  1   sticky: RRESP!=OKAY or RLAST/beat-count mismatch; cleared by RESET only
//  M_AXI_ARADDR        out  32  {DMA_RD_ADDR[28:0] with low log2(BURST_BEATS) bits forced 0, 3'b000}
//  M_AXI_ARLEN         out  4   BURST_BEATS-1 (constant)
//  M_AXI_ARSIZE        out  3   3'b011, 8 bytes (constant)
//  M_AXI_ARBURST       out  2   2'b01, INCR (constant)
//  M_AXI_ARCACHE       out  4   4'b0011 (constant)
//  M_AXI_ARVALID       out  1   address valid
//  M_AXI_ARREADY       in   1   address accepted
//  M_AXI_RDATA         in   64  read beat
//  M_AXI_RRESP         in   2   response, 2'b00 = OKAY
//  M_AXI_RLAST         in   1   last beat of burst
//  M_AXI_RVALID        in   1   beat valid
//  M_AXI_RREADY        out  1   beat accept
// BEHAVIOUR
//  Reset values: DMA_READY=1; ARVALID=0; RREADY=0; DMA_RD_DATA_VALID=0; DMA_RD_DATA=0; DMA_ERROR=0; FSM=IDLE.
//  All outputs are registered.
//  FSM:
//   IDLE: DMA_READY=1. On DMA_START, latch ARADDR; go ADDR. READY=0 and ARVALID=1 the next cycle.
//   ADDR: hold ARVALID and ARADDR stable until ARREADY; on handshake ARVALID=0 next cycle; go DATA.
//   DATA: RREADY = ~hi_pending (register for the pending upper half).
//    - Beat accepted at T: low word out with VALID=1 at T+1; high word out at T+2.
//    - Next beat may be accepted at T+2, so peak output is 1 word/CLK.
//    - Beat counter wraps at BURST_BEATS.
//    - Burst ends on the beat carrying RLAST; go DRAIN.
//   DRAIN: when the last high word has been output, DMA_READY=1 the cycle after; go IDLE.
//  DMA_START outside IDLE is ignored: no queueing, no error.
//  Errors: RRESP!=OKAY on any beat, RLAST before beat BURST_BEATS, or no RLAST on beat BURST_BEATS
//   -> DMA_ERROR=1. Data is still forwarded. Burst terminates on RLAST only.
//  Address alignment: low log2(BURST_BEATS) word bits are forced to 0, so a burst never crosses a 4KB boundary.
//  Reset mid-burst: immediate return to reset values; an outstanding AXI read is abandoned.
//   RESET must be asserted together with the interconnect reset.
//  Only one burst outstanding at a time (no AR pipelining).
// STRUCTURE
//  lcd_dma_pkg: AXI constants (AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_DEFAULT)
//   and the FSM state enum (IDLE, ADDR, DATA, DRAIN).
//  Sub-module lcd_dma_beat_splitter: 64->32 serializer owning hi_pending, RREADY,
//   DMA_RD_DATA and DMA_RD_DATA_VALID.
//  The top level holds the FSM, address latch, beat counter and error logic.
// TESTING
//  1. START with addr 0x10000000, ARREADY=1, 4 back-to-back beats
//     -> ARADDR=0x80000000, ARLEN=3, 8 consecutive VALID words, low halves first, READY after the last word.
//  2. ARREADY held low 5 cycles -> ARVALID and ARADDR stable throughout; no R accepted before the AR handshake.
//  3. Gaps in RVALID (random 0-3 cycles) -> word order and count preserved; RREADY never high while hi_pending.
//  4. DMA_START pulsed in ADDR and DATA states -> ignored; exactly one AR issued per accepted START.
//  5. RRESP=2'b10 on beat 2, or RLAST on beat 3 -> DMA_ERROR=1 and stays 1; READY returns after RLAST.
//  6. RESET asserted mid-DATA -> next cycle all outputs at reset values;
//     new START after release -> clean burst.

Source files
------------

// File: rtl/lcd_dma_pkg.sv
// Shared constants and FSM encoding for the LCD DMA burst reader.
// Holds the fixed AXI3 read attributes and the reader's state enum.
package lcd_dma_pkg;

  localparam logic [2:0] AXI_SIZE_8B       = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } dma_state_t;

endpackage

// File: rtl/lcd_dma_reader_if.sv
// AXI3 read-address and read-data channels between the DMA reader and the HP port.
// The master modport is the reader's view; slave is the memory/interconnect view.
interface lcd_dma_reader_if;

  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/lcd_dma_beat_splitter.sv
// Serializes each accepted 64-bit beat into two 32-bit words, low half first.
// RREADY drops for the cycle the upper half is pending, capping output at one word per clock.
module lcd_dma_beat_splitter (
  input  logic        clk,
  input  logic        srst,
  input  logic        rd_enable,
  input  logic [63:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        beat_accept,
  output logic        hi_pending
);

  logic        rready_reg;
  logic        hi_pending_reg;
  logic        word_valid_reg;
  logic [31:0] word_reg;
  logic [31:0] hi_word_reg;

  assign beat_accept = rvalid & rready_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      rready_reg     <= 1'b0;
      hi_pending_reg <= 1'b0;
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
      hi_word_reg    <= '0;
    end else if (beat_accept) begin
      word_reg       <= rdata[31:0];
      hi_word_reg    <= rdata[63:32];
      word_valid_reg <= 1'b1;
      hi_pending_reg <= 1'b1;
      rready_reg     <= 1'b0;
    end else if (hi_pending_reg) begin
      word_reg       <= hi_word_reg;
      word_valid_reg <= 1'b1;
      hi_pending_reg <= 1'b0;
      rready_reg     <= rd_enable;
    end else begin
      // Data bus is forced to zero whenever no word is presented.
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      rready_reg     <= rd_enable;
    end
  end

  assign rready     = rready_reg;
  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign hi_pending = hi_pending_reg;

endmodule

// File: rtl/lcd_dma_reader.sv
// AXI3 burst-read master for the LCD controller: one aligned INCR burst per DMA_START,
// forwarded as 32-bit words, with a sticky error flag for bad responses or RLAST misplacement.
module lcd_dma_reader #(
  parameter int BURST_BEATS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [29:0] DMA_RD_ADDR,
  input  logic        DMA_START,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  output logic        DMA_ERROR,
  lcd_dma_reader_if.master M_AXI
);

  import lcd_dma_pkg::*;

  localparam int          CNT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [28:0] ALIGN_MASK = 29'(BURST_BEATS - 1);

  dma_state_t       state_reg, state_next;
  logic             ready_reg, ready_next;
  logic             arvalid_reg, arvalid_next;
  logic [31:0]      araddr_reg, araddr_next;
  logic             error_reg, error_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rd_enable;
  logic             beat_accept;
  logic             hi_pending;
  logic             last_expected;
  logic             addr_msb_unused;

  // Word address bit 29 has no place in a 32-bit byte address.
  assign addr_msb_unused = DMA_RD_ADDR[29];
  assign last_expected   = (cnt_reg == CNT_W'(BURST_BEATS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b1;
      arvalid_reg <= 1'b0;
      araddr_reg  <= '0;
      error_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= ready_next;
      arvalid_reg <= arvalid_next;
      araddr_reg  <= araddr_next;
      error_reg   <= error_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (DMA_START) state_next = ADDR;
      ADDR:    if (arvalid_reg && M_AXI.ARREADY) state_next = DATA;
      DATA:    if (beat_accept && M_AXI.RLAST) state_next = DRAIN;
      DRAIN:   if (!hi_pending) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered, so they track it exactly.
  always_comb begin
    ready_next   = (state_next == IDLE);
    arvalid_next = (state_next == ADDR);
    rd_enable    = (state_next == DATA);
    araddr_next  = araddr_reg;
    cnt_next     = cnt_reg;
    error_next   = error_reg;
    if (state_reg == IDLE) begin
      cnt_next = '0;
      if (DMA_START) araddr_next = {DMA_RD_ADDR[28:0] & ~ALIGN_MASK, 3'b000};
    end
    if (beat_accept) begin
      cnt_next = last_expected ? '0 : cnt_reg + 1'b1;
      if ((M_AXI.RRESP != AXI_RESP_OKAY) || (M_AXI.RLAST != last_expected)) error_next = 1'b1;
    end
  end

  lcd_dma_beat_splitter u_splitter (
    .clk         (CLK),
    .srst        (RESET),
    .rd_enable   (rd_enable),
    .rdata       (M_AXI.RDATA),
    .rvalid      (M_AXI.RVALID),
    .rready      (M_AXI.RREADY),
    .word        (DMA_RD_DATA),
    .word_valid  (DMA_RD_DATA_VALID),
    .beat_accept (beat_accept),
    .hi_pending  (hi_pending)
  );

  assign DMA_READY     = ready_reg;
  assign DMA_ERROR     = error_reg;
  assign M_AXI.ARADDR  = araddr_reg;
  assign M_AXI.ARVALID = arvalid_reg;
  assign M_AXI.ARLEN   = 4'(BURST_BEATS - 1);
  assign M_AXI.ARSIZE  = AXI_SIZE_8B;
  assign M_AXI.ARBURST = AXI_BURST_INCR;
  assign M_AXI.ARCACHE = AXI_CACHE_DEFAULT;

endmodule

// File: tb/tb_lcd_dma_reader.sv
// Bench for lcd_dma_reader: a scripted AXI read slave feeds bursts, and a word-queue model
// of the expected DMA stream is checked every cycle alongside directed handshake checks.
module tb_lcd_dma_reader;

  localparam int BEATS = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [29:0] dma_rd_addr;
  logic        dma_start;
  logic        dma_ready;
  logic [31:0] dma_rd_data;
  logic        dma_rd_data_valid;
  logic        dma_error;

  lcd_dma_reader_if axi ();

  lcd_dma_reader #(.BURST_BEATS(BEATS)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DMA_RD_ADDR       (dma_rd_addr),
    .DMA_START         (dma_start),
    .DMA_READY         (dma_ready),
    .DMA_RD_DATA       (dma_rd_data),
    .DMA_RD_DATA_VALID (dma_rd_data_valid),
    .DMA_ERROR         (dma_error),
    .M_AXI             (axi)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          ar_count = 0;
  int          ar_exp = 0;
  logic        err_exp;
  logic        prev_accept = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] rx_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [29:0] a, input int b);
    return {16'hB000 + 16'(b), a[15:0], 16'hA000 + 16'(b), a[15:0]};
  endfunction

  always @(posedge CLK) begin
    prev_accept <= axi.RVALID & axi.RREADY & ~RESET;
    if (!RESET && axi.ARVALID && axi.ARREADY) ar_count <= ar_count + 1;
  end

  // Every word leaving the DUT must be the next one the model expects; idle bus must be zero.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (dma_rd_data_valid) begin
        if (exp_q.size() == 0) check("word_overrun", 64'(exp_q.size()), 64'd1);
        else begin
          check("word", 64'(dma_rd_data), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        rx_log.push_back(dma_rd_data);
      end else begin
        check("idle_data", 64'(dma_rd_data), 64'd0);
      end
      if (prev_accept) check("rready_while_hi_pending", 64'(axi.RREADY), 64'd0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_ready", 64'(dma_ready), 64'd1);
    check("rst_arvalid", 64'(axi.ARVALID), 64'd0);
    check("rst_rready", 64'(axi.RREADY), 64'd0);
    check("rst_valid", 64'(dma_rd_data_valid), 64'd0);
    check("rst_data", 64'(dma_rd_data), 64'd0);
    check("rst_error", 64'(dma_error), 64'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    axi.RVALID = 1'b0;
    axi.RLAST = 1'b0;
    axi.ARREADY = 1'b0;
    step();
    check_reset_values();
    exp_q.delete();
    err_exp = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!dma_ready && n < budget) begin
      step();
      n++;
    end
    check("ready_wait", 64'(dma_ready), 64'd1);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [1:0] resp, input logic last, input int gap);
    int n = 0;
    axi.RVALID = 1'b0;
    repeat (gap) step();
    axi.RDATA = d;
    axi.RRESP = resp;
    axi.RLAST = last;
    axi.RVALID = 1'b1;
    exp_q.push_back(d[31:0]);
    exp_q.push_back(d[63:32]);
    @(negedge CLK);
    while (!axi.RREADY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("rready_wait", 64'(axi.RREADY), 64'd1);
    step();
    axi.RVALID = 1'b0;
    axi.RLAST = 1'b0;
  endtask

  task automatic run_burst(input logic [29:0] addr, input int ar_delay, input int gap_max,
                           input int bad_resp_beat, input int last_beat, input bit poke);
    logic [31:0] exp_addr;
    int          rx0;
    exp_addr = {addr[28:0] & ~29'(BEATS - 1), 3'b000};
    wait_ready(20);
    rx0 = rx_log.size();
    dma_rd_addr = addr;
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    ar_exp++;
    check("arvalid_set", 64'(axi.ARVALID), 64'd1);
    check("ready_clr", 64'(dma_ready), 64'd0);
    check("araddr", 64'(axi.ARADDR), 64'(exp_addr));
    check("arlen", 64'(axi.ARLEN), 64'(BEATS - 1));
    check("ar_const", 64'({axi.ARSIZE, axi.ARBURST, axi.ARCACHE}), 64'({3'b011, 2'b01, 4'b0011}));
    for (int i = 0; i < ar_delay; i++) begin
      if (poke && i == 1) begin
        dma_rd_addr = ~addr;
        dma_start = 1'b1;
      end
      step();
      dma_start = 1'b0;
      dma_rd_addr = addr;
      check("arvalid_hold", 64'(axi.ARVALID), 64'd1);
      check("araddr_hold", 64'(axi.ARADDR), 64'(exp_addr));
      check("rready_in_addr", 64'(axi.RREADY), 64'd0);
    end
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    check("arvalid_drop", 64'(axi.ARVALID), 64'd0);
    for (int b = 0; b <= last_beat; b++) begin
      if (poke && b == 1) begin
        dma_start = 1'b1;
        step();
        dma_start = 1'b0;
      end
      drive_beat(beat_val(addr, b), (b == bad_resp_beat) ? 2'b10 : 2'b00, b == last_beat,
                 (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
      if (b == bad_resp_beat || ((b == last_beat) != (b == BEATS - 1))) err_exp = 1'b1;
    end
    // Last low word is out now, high word next cycle, READY the cycle after that.
    check("ready_low_word", 64'(dma_ready), 64'd0);
    step();
    check("ready_high_word", 64'(dma_ready), 64'd0);
    step();
    check("ready_after_last", 64'(dma_ready), 64'd1);
    check("words_left", 64'(exp_q.size()), 64'd0);
    check("word_total", 64'(rx_log.size() - rx0), 64'(2 * (last_beat + 1)));
    check("error", 64'(dma_error), 64'(err_exp));
    $display("burst araddr=%h beats=%0d words=%0d error=%0b", exp_addr, last_beat + 1,
             rx_log.size() - rx0, dma_error);
  endtask

  initial begin
    RESET = 1'b1;
    dma_start = 1'b0;
    dma_rd_addr = '0;
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b0;
    axi.RDATA = '0;
    axi.RRESP = 2'b00;
    axi.RLAST = 1'b0;
    err_exp = 1'b0;
    repeat (3) step();
    check_reset_values();
    RESET = 1'b0;
    step();

    // Back-to-back beats, word order pinned by literals.
    run_burst(30'h1000_0000, 0, 0, -1, BEATS - 1, 1'b0);
    check("pin_word0", 64'(rx_log[0]), 64'h0000_0000_A000_0000);
    check("pin_word1", 64'(rx_log[1]), 64'h0000_0000_B000_0000);
    check("pin_word2", 64'(rx_log[2]), 64'h0000_0000_A001_0000);
    check("pin_word7", 64'(rx_log[7]), 64'h0000_0000_B003_0000);

    // ARREADY stalled; unaligned address gets its low beat bits cleared.
    run_burst(30'h0123_4567, 5, 0, -1, BEATS - 1, 1'b0);
    check("pin_aligned_addr", 64'(axi.ARADDR), 64'h0000_0000_091A_2B20);

    // Random gaps in RVALID.
    for (int k = 0; k < 3; k++) run_burst(30'(32'h0000_2000 + k * 8), 1, 3, -1, BEATS - 1, 1'b0);

    // Stray starts in ADDR and DATA must not launch another read.
    run_burst(30'h0000_0100, 3, 0, -1, BEATS - 1, 1'b1);
    check("ar_count", 64'(ar_count), 64'(ar_exp));

    // Bad response on beat 2, then error persists across a clean burst.
    run_burst(30'h0000_0200, 0, 1, 1, BEATS - 1, 1'b0);
    run_burst(30'h0000_0300, 0, 0, -1, BEATS - 1, 1'b0);
    check("pin_error_sticky", 64'(dma_error), 64'd1);

    // Early RLAST on beat 3.
    do_reset();
    run_burst(30'h0000_0400, 0, 0, -1, BEATS - 2, 1'b0);

    // Reset in the middle of the data phase, then a clean burst.
    do_reset();
    wait_ready(20);
    dma_rd_addr = 30'h0000_0040;
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    ar_exp++;
    drive_beat(64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0, 0);
    do_reset();
    run_burst(30'h0000_0500, 2, 2, -1, BEATS - 1, 1'b0);
    check("ar_count_final", 64'(ar_count), 64'(ar_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
